// File: rtl/mux_rr_sched_if.sv
// Handshake bundle between the round-robin scheduler, its requesters and the
// downstream consumer of the shared 16:1 mux output.
interface mux_rr_sched_if #(
  parameter int N     = 16,
  parameter int SEL_W = 4
);
  logic [N-1:0]     req;
  logic             out_ready;
  logic [SEL_W-1:0] sel;
  logic [N-1:0]     grant;
  logic             out_valid;
  logic             busy;

  // The scheduler owns the select bus; requesters and consumer drive req/ready.
  modport master (input req, out_ready, output sel, grant, out_valid, busy);
  modport slave  (output req, out_ready, input sel, grant, out_valid, busy);
endinterface

// File: rtl/mux_rr_sched.sv
// Round-robin owner of the mux16to1 select bus: grants one requester for a
// bounded burst of beats, then rotates to the next requester in scan order.
module mux_rr_sched #(
  parameter int N        = 16,
  parameter int SEL_W    = 4,
  parameter int MAX_HOLD = 8
) (
  input logic           clk,
  input logic           rst_n,
  mux_rr_sched_if.master bus
);

  localparam int CNT_W = 8;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [SEL_W-1:0] scan_base;
  logic [SEL_W-1:0] win_idx;
  logic             win_found;
  logic             holder_req;
  logic             beat;
  logic             release_now;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      ptr_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign holder_req  = bus.req[sel_q];
  assign beat        = (state_q == GRANT) && holder_req && bus.out_ready;
  assign release_now = !holder_req || (beat && (beat_cnt_q == CNT_W'(MAX_HOLD - 1)));

  // On release the search starts one past the holder, so the holder comes last.
  assign scan_base = (state_q == GRANT) ? sel_q + SEL_W'(1) : ptr_q;

  // Scanning downward lets the lowest offset from scan_base win; the sum wraps mod N.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.req[scan_base + SEL_W'(i)]) begin
        win_found = 1'b1;
        win_idx   = scan_base + SEL_W'(i);
      end
    end
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d    = GRANT;
          sel_d      = win_idx;
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_d      = sel_q + SEL_W'(1);
          beat_cnt_d = '0;
          if (win_found) begin
            sel_d = win_idx;
          end else begin
            state_d = IDLE;
          end
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // sel keeps its last value in IDLE; grant is forced to zero there instead.
  always_comb begin
    bus.sel       = sel_q;
    bus.grant     = '0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    if (state_q == GRANT) begin
      bus.grant[sel_q] = 1'b1;
      bus.out_valid    = holder_req;
      bus.busy         = 1'b1;
    end
  end

endmodule

// File: tb/tb_mux_rr_sched.sv
// Vector-table bench for mux_rr_sched: expected outputs are queued when each
// vector is driven and compared when the outputs settle mid-cycle.
module tb_mux_rr_sched;

  typedef struct {
    logic [15:0] req;
    logic        rdy;
    logic [3:0]  sel;
    logic [15:0] grant;
    logic        valid;
    logic        busy;
    int          cnt;   // -1: beat counter not checked
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  bit   clk_en = 1'b0;

  int total = 0;
  int bad   = 0;

  vec_t tbl[$];
  vec_t sb_q[$];

  mux_rr_sched_if #(.N(16), .SEL_W(4)) bus ();

  mux_rr_sched #(.N(16), .SEL_W(4), .MAX_HOLD(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [15:0] r, input logic rdy, input logic [3:0] s,
                     input logic [15:0] g, input logic v, input logic b, input int c);
    vec_t e;
    e = '{req: r, rdy: rdy, sel: s, grant: g, valid: v, busy: b, cnt: c};
    tbl.push_back(e);
  endtask

  // Drives one vector, queues its expectation, then compares once outputs settle.
  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    bus.req       = v.req;
    bus.out_ready = v.rdy;
    sb_q.push_back(v);
    #1;
    e = sb_q.pop_front();
    check({tag, ".sel"},   32'(bus.sel),       32'(e.sel));
    check({tag, ".grant"}, 32'(bus.grant),     32'(e.grant));
    check({tag, ".valid"}, 32'(bus.out_valid), 32'(e.valid));
    check({tag, ".busy"},  32'(bus.busy),      32'(e.busy));
    if (e.cnt >= 0) check({tag, ".cnt"}, 32'(dut.beat_cnt_q), 32'(e.cnt));
  endtask

  task automatic run_tbl(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      apply(tbl[i], $sformatf("%s[%0d]", name, i));
    end
    tbl.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    bus.req       = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t v;

    // Reset with every requester active and no clock running.
    rst_n         = 1'b0;
    bus.req       = 16'hFFFF;
    bus.out_ready = 1'b0;
    #2;
    v = '{req: 16'hFFFF, rdy: 1'b0, sel: 4'd0, grant: 16'h0, valid: 1'b0, busy: 1'b0, cnt: 0};
    apply(v, "t1_reset");
    clk_en = 1'b1;

    // Single steady requester: grant one cycle later, re-grant after 8 beats.
    do_reset();
    add(16'h0020, 1, 4'd0, 16'h0000, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(16'h0020, 1, 4'd5, 16'h0020, 1, 1, i);
    for (int i = 0; i < 4; i++) add(16'h0020, 1, 4'd5, 16'h0020, 1, 1, i);
    run_tbl("t2_steady");

    // Two requesters at the ends of the ring: 0, then 15, then wrap back to 0.
    do_reset();
    add(16'h8001, 1, 4'd0, 16'h0000, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(16'h8001, 1, 4'd0,  16'h0001, 1, 1, i);
    for (int i = 0; i < 8; i++) add(16'h8001, 1, 4'd15, 16'h8000, 1, 1, i);
    add(16'h8001, 1, 4'd0, 16'h0001, 1, 1, 0);
    add(16'h8001, 1, 4'd0, 16'h0001, 1, 1, 1);
    run_tbl("t3_wrap");

    // Back-pressure freezes the count; a late request waits for the release.
    do_reset();
    add(16'h0008, 1, 4'd0, 16'h0000, 0, 0, 0);
    add(16'h0008, 1, 4'd3, 16'h0008, 1, 1, 0);
    add(16'h0008, 1, 4'd3, 16'h0008, 1, 1, 1);
    for (int i = 0; i < 5; i++) add(16'h0008, 0, 4'd3, 16'h0008, 1, 1, 2);
    for (int i = 0; i < 6; i++) add(16'h0408, 1, 4'd3, 16'h0008, 1, 1, 2 + i);
    add(16'h0408, 1, 4'd10, 16'h0400, 1, 1, 0);
    run_tbl("t4_stall");

    // Holder withdraws: switch without idle cycle, then idle, then wrapped search.
    do_reset();
    add(16'h0204, 1, 4'd0, 16'h0000, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(16'h0204, 1, 4'd2, 16'h0004, 1, 1, i);
    add(16'h0200, 1, 4'd2, 16'h0004, 0, 1, 3);
    add(16'h0200, 1, 4'd9, 16'h0200, 1, 1, 0);
    add(16'h0000, 1, 4'd9, 16'h0200, 0, 1, 1);
    add(16'h0000, 1, 4'd9, 16'h0000, 0, 0, -1);
    add(16'h0204, 1, 4'd9, 16'h0000, 0, 0, -1);
    add(16'h0204, 1, 4'd2, 16'h0004, 1, 1, 0);
    run_tbl("t5_drop");

    // Asynchronous reset in the middle of a burst held by requester 4.
    do_reset();
    add(16'h0010, 1, 4'd0, 16'h0000, 0, 0, 0);
    add(16'h0010, 1, 4'd4, 16'h0010, 1, 1, 0);
    for (int i = 1; i < 4; i++) add(16'hFFFF, 1, 4'd4, 16'h0010, 1, 1, i);
    run_tbl("t6_pre");
    @(posedge clk);
    #2;
    check("t6_mid_cnt", 32'(dut.beat_cnt_q), 32'd4);
    rst_n = 1'b0;
    v = '{req: 16'hFFFF, rdy: 1'b1, sel: 4'd0, grant: 16'h0, valid: 1'b0, busy: 1'b0, cnt: 0};
    apply(v, "t6_async");
    @(negedge clk);
    rst_n = 1'b1;
    add(16'hFFFF, 1, 4'd0, 16'h0001, 1, 1, 0);
    add(16'hFFFF, 1, 4'd0, 16'h0001, 1, 1, 1);
    run_tbl("t6_post");

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
